// File: rtl/riscv_definitions.sv
// Shared types for the load/store unit: bus/register types, funct3 encodings,
// LSU FSM states and the byte-enable, store-replication and load-extension helpers.
package riscv_definitions;

    typedef logic [31:0] dataBus_t;
    typedef logic [4:0]  regAddr_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } loadFunct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } storeFunct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsuState_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } accSize_e;

    // Anything outside the defined funct3 codes of the class falls back to a word access.
    function automatic accSize_e access_size(input logic is_load, input logic [2:0] funct3);
        accSize_e sz;
        sz = SZ_WORD;
        if (is_load) begin
            case (funct3)
                LB, LBU: sz = SZ_BYTE;
                LH, LHU: sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                SB:      sz = SZ_BYTE;
                SH:      sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic dataBus_t align_addr(input accSize_e size, input dataBus_t addr);
        dataBus_t res;
        case (size)
            SZ_BYTE: res = addr;
            SZ_HALF: res = {addr[31:1], 1'b0};
            default: res = {addr[31:2], 2'b00};
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input accSize_e size, input logic [1:0] offset);
        logic res;
        case (size)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = offset[0];
            default: res = (offset != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_be(input accSize_e size, input logic [1:0] offset);
        logic [3:0] res;
        case (size)
            SZ_BYTE: res = 4'b0001 << offset;
            SZ_HALF: res = 4'b0011 << {offset[1], 1'b0};
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic dataBus_t store_data(input accSize_e size, input dataBus_t wdata);
        dataBus_t res;
        case (size)
            SZ_BYTE: res = {4{wdata[7:0]}};
            SZ_HALF: res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Lane already shifted down to bit 0; extend according to size and signedness.
    function automatic dataBus_t load_extend(input accSize_e size, input logic is_unsigned,
                                             input dataBus_t lane);
        dataBus_t res;
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'h00_0000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: res = is_unsigned ? {16'h0000, lane[15:0]}   : {{16{lane[15]}}, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
    import riscv_definitions::*;

    logic       dmem_req_o;
    logic       dmem_we_o;
    logic [3:0] dmem_be_o;
    dataBus_t   dmem_addr_o;
    dataBus_t   dmem_wdata_o;
    logic       dmem_gnt_i;
    logic       dmem_rvalid_i;
    dataBus_t   dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load return path: selects the little-endian lane addressed by the access offset
// and sign/zero-extends it to 32 bits.
module lsu_load_align
    import riscv_definitions::*;
(
    input  dataBus_t   i_rdata,
    input  logic [1:0] i_offset,
    input  accSize_e   i_size,
    input  logic       i_unsigned,
    output dataBus_t   o_data
);

    dataBus_t w_shifted;

    // Shift the addressed lane to bit 0, then extend.
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_data    = load_extend(i_size, i_unsigned, w_shifted);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE/REQ/WAIT FSM with grant handshake and
// read-data timeout. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit
    import riscv_definitions::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ex_valid_i,
    input  logic     ex_is_load_i,
    input  logic     ex_is_store_i,
    input  logic [2:0] ex_funct3_i,
    input  dataBus_t ex_addr_i,
    input  dataBus_t ex_wdata_i,
    input  regAddr_t ex_rd_i,
    output logic     stall_o,
    output logic     wb_valid_o,
    output regAddr_t wb_rd_o,
    output dataBus_t wb_data_o,
    output logic     bus_err_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic     misalign_o,
`endif
    load_store_unit_if.master dmem
);

    localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(DMEM_TIMEOUT - 1);

    lsuState_e     r_state;
    logic          r_is_load;
    accSize_e      r_size;
    logic          r_unsigned;
    logic [1:0]    r_offset;
    regAddr_t      r_rd;
    logic [CW-1:0] r_wait_cnt;
    logic          r_dmem_req;
    logic          r_dmem_we;
    logic [3:0]    r_dmem_be;
    dataBus_t      r_dmem_addr;
    dataBus_t      r_dmem_wdata;
    logic          r_wb_valid;
    regAddr_t      r_wb_rd;
    dataBus_t      r_wb_data;
    logic          r_bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          r_misalign;
`endif

    logic     w_accept;
    logic     w_misalign;
    logic     w_start;
    logic     w_store_done;
    logic     w_load_done;
    logic     w_timeout;
    accSize_e w_size;
    dataBus_t w_addr_al;
    dataBus_t w_load_data;

    lsu_load_align u_load_align (
        .i_rdata    (dmem.dmem_rdata_i),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Accept decode, completion events and the combinational stall.
    always_comb begin
        w_accept  = (r_state == IDLE) && ex_valid_i && (ex_is_load_i || ex_is_store_i);
        w_size    = access_size(ex_is_load_i, ex_funct3_i);
        w_addr_al = align_addr(w_size, ex_addr_i);
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = is_misaligned(w_size, ex_addr_i[1:0]);
`else
        w_misalign = 1'b0;
`endif
        w_start      = w_accept && !w_misalign;
        w_store_done = (r_state == REQ) && dmem.dmem_gnt_i && !r_is_load;
        w_load_done  = (r_state == WAIT) && dmem.dmem_rvalid_i;
        w_timeout    = (r_state == WAIT) && !dmem.dmem_rvalid_i && (r_wait_cnt == TO_LAST);
        stall_o      = w_start
                     || ((r_state == REQ) && !w_store_done)
                     || ((r_state == WAIT) && !w_load_done && !w_timeout);
    end

    // Access FSM with registered bus, writeback and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_is_load    <= 1'b0;
            r_size       <= SZ_WORD;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_rd         <= 5'd0;
            r_wait_cnt   <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= 4'b0000;
            r_dmem_addr  <= 32'h0000_0000;
            r_dmem_wdata <= 32'h0000_0000;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'h0000_0000;
            r_bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
            r_bus_err  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= w_accept && w_misalign;
`endif
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= REQ;
                        r_is_load    <= ex_is_load_i;
                        r_size       <= w_size;
                        r_unsigned   <= ex_funct3_i[2];
                        r_offset     <= w_addr_al[1:0];
                        r_rd         <= ex_rd_i;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= !ex_is_load_i;
                        r_dmem_be    <= store_be(w_size, w_addr_al[1:0]);
                        r_dmem_addr  <= {w_addr_al[31:2], 2'b00};
                        r_dmem_wdata <= store_data(w_size, ex_wdata_i);
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt_i) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= r_is_load ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rvalid_i) begin
                        r_state    <= IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        r_bus_err  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_dmem_req <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_req_o   = r_dmem_req;
    assign dmem.dmem_we_o    = r_dmem_we;
    assign dmem.dmem_be_o    = r_dmem_be;
    assign dmem.dmem_addr_o  = r_dmem_addr;
    assign dmem.dmem_wdata_o = r_dmem_wdata;
    assign wb_valid_o        = r_wb_valid;
    assign wb_rd_o           = r_wb_rd;
    assign wb_data_o         = r_wb_data;
    assign bus_err_o         = r_bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o        = r_misalign;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, sign/zero-extended loads, grant delay,
// read timeout, alignment handling and reset during an outstanding load.
module tb_load_store_unit;
    import riscv_definitions::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_is_load, ex_is_store;
    logic [2:0] ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0] ex_rd;
    logic       stall, wb_valid, bus_err;
    logic [4:0] wb_rd;
    logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic       misalign;
`endif
    int n_chk  = 0;
    int n_pass = 0;

    load_store_unit_if dmem_bus ();

    load_store_unit #(.DMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load),
        .ex_is_store_i(ex_is_store), .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr),
        .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd), .stall_o(stall), .wb_valid_o(wb_valid),
        .wb_rd_o(wb_rd), .wb_data_o(wb_data), .bus_err_o(bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o(misalign),
`endif
        .dmem(dmem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] a, output logic [31:0] w,
                             output logic we, output int stall_cycles, output int req_cycles);
        stall_cycles = 0; req_cycles = 0; be = 4'b0000; a = 32'h0; w = 32'h0; we = 1'b0;
        tick();
        ex_valid = 1'b1; ex_is_store = 1'b1; ex_is_load = 1'b0;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
        @(negedge clk);
        if (stall) stall_cycles++;
        if (dmem_bus.dmem_req_o) req_cycles++;
        tick();
        ex_valid = 1'b0; ex_is_store = 1'b0; dmem_bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        if (stall) stall_cycles++;
        if (dmem_bus.dmem_req_o) begin
            req_cycles++;
            be = dmem_bus.dmem_be_o; a = dmem_bus.dmem_addr_o;
            w = dmem_bus.dmem_wdata_o; we = dmem_bus.dmem_we_o;
        end
        tick();
        dmem_bus.dmem_gnt_i = 1'b0;
        @(negedge clk);
        if (stall) stall_cycles++;
        if (dmem_bus.dmem_req_o) req_cycles++;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                            output int req_cycles, output logic [31:0] req_addr,
                            output logic addr_moved, output int stall_cycles,
                            output int wb_pulses, output int wb_first,
                            output logic [31:0] wbd, output logic [4:0] wbr);
        req_cycles = 0; req_addr = 32'h0; addr_moved = 1'b0; stall_cycles = 0;
        wb_pulses = 0; wb_first = -1; wbd = 32'h0; wbr = 5'd0;
        tick();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_funct3 = f3; ex_addr = addr; ex_rd = rd;
        @(negedge clk);
        if (stall) stall_cycles++;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) dmem_bus.dmem_gnt_i = 1'b1;
            @(negedge clk);
            if (stall) stall_cycles++;
            if (dmem_bus.dmem_req_o) begin
                if (req_cycles == 0) req_addr = dmem_bus.dmem_addr_o;
                else if (dmem_bus.dmem_addr_o !== req_addr) addr_moved = 1'b1;
                req_cycles++;
            end
            tick();
        end
        dmem_bus.dmem_gnt_i = 1'b0;
        for (int i = 0; i <= rv_wait; i++) begin
            if (i == rv_wait) begin
                dmem_bus.dmem_rvalid_i = 1'b1; dmem_bus.dmem_rdata_i = rdata;
            end
            @(negedge clk);
            if (stall) stall_cycles++;
            tick();
        end
        dmem_bus.dmem_rvalid_i = 1'b0; dmem_bus.dmem_rdata_i = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_first < 0) wb_first = i;
                wb_pulses++; wbd = wb_data; wbr = wb_rd;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        dmem_bus.dmem_gnt_i = 1'b0; dmem_bus.dmem_rvalid_i = 1'b0; dmem_bus.dmem_rdata_i = 32'h0;
        repeat (2) tick();
        @(negedge clk);
        n_chk++; if ({dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, wb_valid, bus_err, stall} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b expected 00000", {dmem_bus.dmem_req_o, dmem_bus.dmem_we_o, wb_valid, bus_err, stall}); else n_pass++;
        n_chk++; if ({dmem_bus.dmem_be_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o} !== 68'h0)
            $display("FAIL reset_bus: be %b addr %h wdata %h expected zeros", dmem_bus.dmem_be_o, dmem_bus.dmem_addr_o, dmem_bus.dmem_wdata_o); else n_pass++;
        n_chk++; if ({wb_rd, wb_data} !== 37'h0) $display("FAIL reset_wb: rd %0d data %h expected 0", wb_rd, wb_data); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_store_byte();
        logic [3:0] be; logic [31:0] a, w; logic we; int sc, rc;
        run_store(SB, 32'h0000_1003, 32'h0000_00AB, be, a, w, we, sc, rc);
        n_chk++; if (be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", be); else n_pass++;
        n_chk++; if (w !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h expected ababab ab", w); else n_pass++;
        n_chk++; if (a !== 32'h0000_1000) $display("FAIL sb_addr: got %h expected 00001000", a); else n_pass++;
        n_chk++; if (we !== 1'b1) $display("FAIL sb_we: got %b expected 1", we); else n_pass++;
        n_chk++; if (sc !== 1 || rc !== 1) $display("FAIL sb_timing: stall %0d req %0d expected 1 1", sc, rc); else n_pass++;
    endtask

    task automatic test_store_sizes();
        logic [3:0] be; logic [31:0] a, w; logic we; int sc, rc;
        run_store(SH, 32'h0000_1002, 32'h1234_5678, be, a, w, we, sc, rc);
        n_chk++; if ({be, w} !== {4'b1100, 32'h5678_5678}) $display("FAIL sh_hi: be %b wdata %h expected 1100 56785678", be, w); else n_pass++;
        run_store(SW, 32'h0000_100C, 32'hCAFE_F00D, be, a, w, we, sc, rc);
        n_chk++; if ({be, a, w} !== {4'b1111, 32'h0000_100C, 32'hCAFE_F00D}) $display("FAIL sw: be %b addr %h wdata %h expected 1111 0000100c cafef00d", be, a, w); else n_pass++;
        run_store(3'b111, 32'h0000_9004, 32'h0102_0304, be, a, w, we, sc, rc);
        n_chk++; if ({be, w} !== {4'b1111, 32'h0102_0304}) $display("FAIL s_undef: be %b wdata %h expected 1111 01020304", be, w); else n_pass++;
    endtask

    task automatic test_load_byte();
        int rc, sc, wp, wf; logic [31:0] ra, d; logic mv; logic [4:0] r;
        run_load(LB, 32'h0000_2001, 5'd5, 32'h0000_8000, 0, 1, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (d !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h expected ffffff80", d); else n_pass++;
        n_chk++; if (wp !== 1 || wf !== 0) $display("FAIL lb_pulse: pulses %0d first %0d expected 1 0", wp, wf); else n_pass++;
        n_chk++; if (r !== 5'd5) $display("FAIL lb_rd: got %0d expected 5", r); else n_pass++;
        n_chk++; if ({ra, rc, sc} !== {32'h0000_2000, 32'd1, 32'd3}) $display("FAIL lb_bus: addr %h req %0d stall %0d expected 00002000 1 3", ra, rc, sc); else n_pass++;
    endtask

    task automatic test_load_ext();
        int rc, sc, wp, wf; logic [31:0] ra, d; logic mv; logic [4:0] r;
        run_load(LHU, 32'h0000_2002, 5'd6, 32'hBEEF_1234, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (d !== 32'h0000_BEEF) $display("FAIL lhu_data: got %h expected 0000beef", d); else n_pass++;
        run_load(LH, 32'h0000_2002, 5'd7, 32'h8001_0000, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (d !== 32'hFFFF_8001) $display("FAIL lh_data: got %h expected ffff8001", d); else n_pass++;
        run_load(LBU, 32'h0000_2003, 5'd8, 32'h9A00_0000, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (d !== 32'h0000_009A) $display("FAIL lbu_data: got %h expected 0000009a", d); else n_pass++;
        run_load(3'b011, 32'h0000_9000, 5'd9, 32'h8765_4321, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (d !== 32'h8765_4321) $display("FAIL l_undef: got %h expected 87654321", d); else n_pass++;
        repeat (2) tick();
        @(negedge clk);
        n_chk++; if ({wb_valid, wb_data} !== {1'b0, 32'h8765_4321}) $display("FAIL wb_hold: valid %b data %h expected 0 87654321", wb_valid, wb_data); else n_pass++;
    endtask

    task automatic test_gnt_delay();
        int rc, sc, wp, wf; logic [31:0] ra, d; logic mv; logic [4:0] r;
        run_load(LW, 32'h0000_600C, 5'd10, 32'h1122_3344, 3, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if (rc !== 4 || mv !== 1'b0) $display("FAIL gnt_req: req cycles %0d moved %b expected 4 0", rc, mv); else n_pass++;
        n_chk++; if (ra !== 32'h0000_600C) $display("FAIL gnt_addr: got %h expected 0000600c", ra); else n_pass++;
        n_chk++; if (sc !== 5) $display("FAIL gnt_stall: got %0d expected 5", sc); else n_pass++;
        n_chk++; if ({wp, d} !== {32'd1, 32'h1122_3344}) $display("FAIL gnt_data: pulses %0d data %h expected 1 11223344", wp, d); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [3:0] s; int errs, wbs;
        s = 4'b0000; errs = 0; wbs = 0;
        tick();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = LW; ex_addr = 32'h0000_4000; ex_rd = 5'd11;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0; dmem_bus.dmem_gnt_i = 1'b1;
        tick();
        dmem_bus.dmem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s[i] = stall;
            if (bus_err) errs++;
            if (wb_valid) wbs++;
            tick();
        end
        ex_valid = 1'b1; ex_is_store = 1'b1; ex_funct3 = SW; ex_addr = 32'h0000_5000; ex_wdata = 32'h0;
        @(negedge clk);
        n_chk++; if (s !== 4'b0111) $display("FAIL to_stall: got %b expected 0111", s); else n_pass++;
        n_chk++; if ({errs, bus_err} !== {32'd0, 1'b1}) $display("FAIL to_err: early %0d bus_err %b expected 0 1", errs, bus_err); else n_pass++;
        n_chk++; if ({wbs, wb_valid} !== {32'd0, 1'b0}) $display("FAIL to_wb: %0d %b expected 0 0", wbs, wb_valid); else n_pass++;
        n_chk++; if (stall !== 1'b1) $display("FAIL to_idle: accept stall %b expected 1", stall); else n_pass++;
        tick();
        ex_valid = 1'b0; ex_is_store = 1'b0; dmem_bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus_err, dmem_bus.dmem_req_o} !== 2'b01) $display("FAIL to_after: bus_err,req %b expected 01", {bus_err, dmem_bus.dmem_req_o}); else n_pass++;
        tick();
        dmem_bus.dmem_gnt_i = 1'b0;
    endtask

    task automatic test_align();
`ifdef LSU_MISALIGN_TRAP_EN
        tick();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = LW; ex_addr = 32'h0000_3002; ex_rd = 5'd12;
        @(negedge clk);
        n_chk++; if ({stall, dmem_bus.dmem_req_o} !== 2'b00) $display("FAIL mis_accept: stall,req %b expected 00", {stall, dmem_bus.dmem_req_o}); else n_pass++;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        @(negedge clk);
        n_chk++; if ({misalign, dmem_bus.dmem_req_o, stall} !== 3'b100) $display("FAIL mis_pulse: mis,req,stall %b expected 100", {misalign, dmem_bus.dmem_req_o, stall}); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if ({misalign, dmem_bus.dmem_req_o} !== 2'b00) $display("FAIL mis_end: mis,req %b expected 00", {misalign, dmem_bus.dmem_req_o}); else n_pass++;
`else
        int rc, sc, wp, wf; logic [31:0] ra, d; logic mv; logic [4:0] r;
        logic [3:0] be; logic [31:0] a, w; logic we;
        run_load(LW, 32'h0000_3002, 5'd12, 32'hA5A5_0F0F, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if ({ra, d} !== {32'h0000_3000, 32'hA5A5_0F0F}) $display("FAIL fa_lw: addr %h data %h expected 00003000 a5a50f0f", ra, d); else n_pass++;
        run_load(LH, 32'h0000_7003, 5'd13, 32'hCAFE_0000, 0, 0, rc, ra, mv, sc, wp, wf, d, r);
        n_chk++; if ({ra, d} !== {32'h0000_7000, 32'hFFFF_CAFE}) $display("FAIL fa_lh: addr %h data %h expected 00007000 ffffcafe", ra, d); else n_pass++;
        run_store(SH, 32'h0000_1001, 32'h1234_5678, be, a, w, we, sc, rc);
        n_chk++; if ({be, w} !== {4'b0011, 32'h5678_5678}) $display("FAIL fa_sh: be %b wdata %h expected 0011 56785678", be, w); else n_pass++;
`endif
    endtask

    task automatic test_reset_in_wait();
        int wbs;
        wbs = 0;
        tick();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = LW; ex_addr = 32'h0000_8000; ex_rd = 5'd14;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0; dmem_bus.dmem_gnt_i = 1'b1;
        tick();
        dmem_bus.dmem_gnt_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if ({stall, dmem_bus.dmem_req_o, wb_data} !== 34'h0) $display("FAIL rw_reset: stall %b req %b wb_data %h expected 0 0 0", stall, dmem_bus.dmem_req_o, wb_data); else n_pass++;
        tick();
        dmem_bus.dmem_rvalid_i = 1'b1; dmem_bus.dmem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL rw_stall: got %b expected 0", stall); else n_pass++;
        tick();
        dmem_bus.dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid) wbs++;
            tick();
        end
        n_chk++; if ({wbs, wb_data} !== {32'd0, 32'h0}) $display("FAIL rw_ignore: pulses %0d data %h expected 0 0", wbs, wb_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_sizes();
        test_load_byte();
        test_load_ext();
        test_gnt_delay();
        test_timeout();
        test_align();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
